bomb_ctrl: RTL

Bomb lifecycle controller sitting directly downstream of the player movement block. It consumes the player's `bomb_drop` request and position, snaps a bomb to the tile grid, and runs the fuse, blast and cooldown timing. During the blast it produces two clipped blast rectangles (horizontal and vertical arm of the cross). The player block consumes these for hit detection; the renderer consumes them for drawing.

---
 rtl/bomb_ctrl.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/bomb_ctrl.sv
// ---------------------------------------------------------------------------
// bomb_ctrl
//
// Bomb lifecycle controller downstream of the player movement block. A rising
// edge on bomb_drop places a bomb snapped to the tile grid under the player's
// centre. The bomb then runs fuse -> blast -> cooldown timing. During the blast
// two clipped rectangles (horizontal and vertical arm of the cross) are
// presented for hit detection and drawing.
//
// Ports
//   frame_clk          in   frame-rate clock, all state changes on rising edge
//   Reset              in   asynchronous active-high reset
//   bomb_drop          in   drop request level (held while the key is held)
//   userX, userY       in   player top-left position (10 bits each)
//   bombX, bombY       out  top-left of the placed bomb tile
//   bomb_active        out  high while the fuse burns (ARMED)
//   exploding          out  high during BLAST
//   hX, hY, hXS, hYS   out  horizontal arm: origin plus (size-1)
//   vX, vY, vXS, vYS   out  vertical arm: origin plus (size-1)
//   state              out  IDLE=0, ARMED=1, BLAST=2, COOLDOWN=3
//
// All outputs are registered; there is no combinational input-to-output path.
// Rectangle outputs are zero outside BLAST.
// ---------------------------------------------------------------------------
module bomb_ctrl #(
  parameter int TILE_LOG2    = 5,
  parameter int RANGE        = 2,
  parameter int FUSE_FRAMES  = 120,
  parameter int BLAST_FRAMES = 30,
  parameter int COOL_FRAMES  = 30,
  parameter int USER_W       = 19,
  parameter int USER_H       = 26,
  parameter int SCR_W        = 640,
  parameter int SCR_H        = 480
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       bomb_drop,
  input  logic [9:0] userX,
  input  logic [9:0] userY,
  output logic [9:0] bombX,
  output logic [9:0] bombY,
  output logic       bomb_active,
  output logic       exploding,
  output logic [9:0] hX,
  output logic [9:0] hY,
  output logic [9:0] hXS,
  output logic [9:0] hYS,
  output logic [9:0] vX,
  output logic [9:0] vY,
  output logic [9:0] vXS,
  output logic [9:0] vYS,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    BLAST    = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  localparam int TILE = 1 << TILE_LOG2;
  localparam int REACH = RANGE * TILE;

  localparam int MAX_FB  = (FUSE_FRAMES > BLAST_FRAMES) ? FUSE_FRAMES : BLAST_FRAMES;
  localparam int MAX_ALL = (MAX_FB > COOL_FRAMES) ? MAX_FB : COOL_FRAMES;
  localparam int CNT_MAX = MAX_ALL - 1;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] FUSE_LOAD  = CNT_W'(FUSE_FRAMES - 1);
  localparam logic [CNT_W-1:0] BLAST_LOAD = CNT_W'(BLAST_FRAMES - 1);
  localparam logic [CNT_W-1:0] COOL_LOAD  = CNT_W'(COOL_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  localparam logic [9:0]  HALF_W  = 10'(USER_W / 2);
  localparam logic [9:0]  HALF_H  = 10'(USER_H / 2);
  localparam logic [9:0]  R10     = 10'(REACH);
  localparam logic [9:0]  TM1     = 10'(TILE - 1);
  localparam logic [10:0] R11     = 11'(REACH);
  localparam logic [10:0] T11     = 11'(TILE);
  localparam logic [10:0] XLIM    = 11'(SCR_W);
  localparam logic [10:0] YLIM    = 11'(SCR_H);

  // Arm start: bomb coordinate minus reach, clamped at 0.
  function automatic logic [9:0] lo_f(input logic [9:0] c);
    return (c >= R10) ? (c - R10) : '0;
  endfunction

  // Arm size-1: end of the arm (clamped to the screen limit) minus start.
  // The end is formed in 11 bits so c + reach + tile cannot wrap.
  function automatic logic [9:0] span_f(input logic [9:0] c, input logic [10:0] lim);
    logic [10:0] e;
    logic [10:0] h;
    e = {1'b0, c} + R11 + T11;
    h = (e < lim) ? e : lim;
    return 10'(h - {1'b0, lo_f(c)} - 11'd1);
  endfunction

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             drop_q;
  logic [9:0]       bomb_x_q, bomb_y_q;
  logic             active_q, expl_q;
  logic [9:0]       hx_q, hy_q, hxs_q, hys_q;
  logic [9:0]       vx_q, vy_q, vxs_q, vys_q;

  logic             req;
  logic             cnt_zero;
  logic [9:0]       snap_x_d, snap_y_d;
  logic [9:0]       hx_d, hxs_d, vy_d, vys_d;

  always_comb begin
    req      = bomb_drop & ~drop_q;
    cnt_zero = (cnt_q == '0);
    // Centre of the sprite, truncated down to the tile grid.
    snap_x_d = ((userX + HALF_W) >> TILE_LOG2) << TILE_LOG2;
    snap_y_d = ((userY + HALF_H) >> TILE_LOG2) << TILE_LOG2;
    hx_d     = lo_f(bomb_x_q);
    hxs_d    = span_f(bomb_x_q, XLIM);
    vy_d     = lo_f(bomb_y_q);
    vys_d    = span_f(bomb_y_q, YLIM);
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      drop_q   <= 1'b0;
      bomb_x_q <= '0;
      bomb_y_q <= '0;
      active_q <= 1'b0;
      expl_q   <= 1'b0;
      hx_q     <= '0;
      hy_q     <= '0;
      hxs_q    <= '0;
      hys_q    <= '0;
      vx_q     <= '0;
      vy_q     <= '0;
      vxs_q    <= '0;
      vys_q    <= '0;
    end else begin
      // Edge detector runs in every state so a key held through a whole
      // bomb cycle cannot re-trigger when IDLE is reached again.
      drop_q <= bomb_drop;
      case (state_q)
        IDLE: begin
          if (req) begin
            bomb_x_q <= snap_x_d;
            bomb_y_q <= snap_y_d;
            cnt_q    <= FUSE_LOAD;
            active_q <= 1'b1;
            state_q  <= ARMED;
          end
        end
        ARMED: begin
          if (cnt_zero) begin
            cnt_q    <= BLAST_LOAD;
            active_q <= 1'b0;
            expl_q   <= 1'b1;
            hx_q     <= hx_d;
            hy_q     <= bomb_y_q;
            hxs_q    <= hxs_d;
            hys_q    <= TM1;
            vx_q     <= bomb_x_q;
            vy_q     <= vy_d;
            vxs_q    <= TM1;
            vys_q    <= vys_d;
            state_q  <= BLAST;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        BLAST: begin
          if (cnt_zero) begin
            cnt_q   <= COOL_LOAD;
            expl_q  <= 1'b0;
            hx_q    <= '0;
            hy_q    <= '0;
            hxs_q   <= '0;
            hys_q   <= '0;
            vx_q    <= '0;
            vy_q    <= '0;
            vxs_q   <= '0;
            vys_q   <= '0;
            state_q <= COOLDOWN;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        COOLDOWN: begin
          if (cnt_zero) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bombX       = bomb_x_q;
  assign bombY       = bomb_y_q;
  assign bomb_active = active_q;
  assign exploding   = expl_q;
  assign hX          = hx_q;
  assign hY          = hy_q;
  assign hXS         = hxs_q;
  assign hYS         = hys_q;
  assign vX          = vx_q;
  assign vY          = vy_q;
  assign vXS         = vxs_q;
  assign vYS         = vys_q;
  assign state       = state_q;

endmodule
